frame_bank_scheduler: RTL and testbench



---
 rtl/frame_bank_scheduler_pkg.sv | 23 ++
 rtl/frame_bank_scheduler_if.sv | 35 +++
 rtl/frame_bank_scheduler_sync_edge_det.sv | 17 +
 rtl/frame_bank_scheduler.sv | 102 ++++++++++
 tb/tb_frame_bank_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_bank_scheduler_pkg.sv
// rtl/frame_bank_scheduler_pkg.sv - shared types, defaults and bank selection helper
package frame_bank_scheduler_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_FLUSH  = 2'd2
  } wr_state_t;

  localparam int          DEF_ADDR_W    = 28;
  localparam logic [27:0] DEF_BANK_SIZE = 28'h080_0000;

  // Lowest bank index that is neither excluded bank; with at least three banks one always exists.
  function automatic logic [1:0] next_free_bank(input logic [1:0] excl_a, input logic [1:0] excl_b);
    logic [1:0] pick;
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (2'(i) != excl_a && 2'(i) != excl_b) pick = 2'(i);
    end
    return pick;
  endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// rtl/frame_bank_scheduler_if.sv - sync/handshake inputs and bank/counter outputs of the scheduler
interface frame_bank_scheduler_if
  import frame_bank_scheduler_pkg::*;
#(
  parameter int BANK_W = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 11
);
  logic              Enable;
  logic              Wr_Sync;
  logic              Wr_Done;
  logic              Rd_Sync;
  logic [BANK_W-1:0] Wr_Bank;
  logic [BANK_W-1:0] Rd_Bank;
  logic [ADDR_W-1:0] Wr_Base_Addr;
  logic [ADDR_W-1:0] Rd_Base_Addr;
  logic              Wr_Frame_Start;
  logic              Rd_Frame_Start;
  logic [CNT_W-1:0]  Frame_I_Cnt;
  logic [CNT_W-1:0]  Frame_O_Cnt;
  logic [CNT_W-1:0]  Drop_Cnt;
  logic [CNT_W-1:0]  Repeat_Cnt;

  modport master (
    output Enable, Wr_Sync, Wr_Done, Rd_Sync,
    input  Wr_Bank, Rd_Bank, Wr_Base_Addr, Rd_Base_Addr, Wr_Frame_Start, Rd_Frame_Start,
    input  Frame_I_Cnt, Frame_O_Cnt, Drop_Cnt, Repeat_Cnt
  );

  modport slave (
    input  Enable, Wr_Sync, Wr_Done, Rd_Sync,
    output Wr_Bank, Rd_Bank, Wr_Base_Addr, Rd_Base_Addr, Wr_Frame_Start, Rd_Frame_Start,
    output Frame_I_Cnt, Frame_O_Cnt, Drop_Cnt, Repeat_Cnt
  );
endinterface

// File: rtl/frame_bank_scheduler_sync_edge_det.sv
// rtl/frame_bank_scheduler_sync_edge_det.sv - rising-edge detector on a pre-synchronised sync level
module sync_edge_det (
  input  logic Clk,
  input  logic Rst_n,
  input  logic sync,
  output logic rise
);
  logic r_sync;

  // Reset to 1 so a sync level already high when reset lifts is not taken as an edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_sync <= 1'b1;
    else        r_sync <= sync;
  end

  assign rise = sync & ~r_sync;
endmodule

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - triple/quad frame-bank rotation between camera writer and HDMI reader
module frame_bank_scheduler
  import frame_bank_scheduler_pkg::*;
#(
  parameter int                BANK_NUM  = 3,
  parameter int                BANK_W    = 2,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(DEF_BANK_SIZE),
  parameter int                CNT_W     = 11
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  frame_bank_scheduler_if.slave bus
);
  wr_state_t         state;
  logic [BANK_W-1:0] latest;
  logic              fresh;
  logic              valid;
  logic              wr_rise;
  logic              rd_rise;
  logic              rd_go;
  logic              commit;
  logic              fresh_after_rd;
  logic [BANK_W-1:0] rd_bank_nx;
  logic [BANK_W-1:0] wr_bank_nx;

  sync_edge_det u_wr_edge (.Clk(Clk), .Rst_n(Rst_n), .sync(bus.Wr_Sync), .rise(wr_rise));
  sync_edge_det u_rd_edge (.Clk(Clk), .Rst_n(Rst_n), .sync(bus.Rd_Sync), .rise(rd_rise));

  // The read hand-over resolves first so a same-cycle commit sees the post-read bank and Fresh.
  always_comb begin
    rd_go          = bus.Enable && valid && rd_rise;
    rd_bank_nx     = (rd_go && fresh) ? latest : bus.Rd_Bank;
    fresh_after_rd = fresh && !rd_go;
    commit         = (state == W_FLUSH) && bus.Wr_Done;
    wr_bank_nx     = commit ? BANK_W'(next_free_bank(2'(bus.Wr_Bank), 2'(rd_bank_nx)))
                            : bus.Wr_Bank;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state              <= W_IDLE;
      latest             <= BANK_W'(1);
      fresh              <= 1'b0;
      valid              <= 1'b0;
      bus.Wr_Bank        <= '0;
      bus.Rd_Bank        <= BANK_W'(BANK_NUM - 1);
      bus.Wr_Base_Addr   <= '0;
      bus.Rd_Base_Addr   <= ADDR_W'(BANK_NUM - 1) * BANK_SIZE;
      bus.Wr_Frame_Start <= 1'b0;
      bus.Rd_Frame_Start <= 1'b0;
      bus.Frame_I_Cnt    <= '0;
      bus.Frame_O_Cnt    <= '0;
      bus.Drop_Cnt       <= '0;
      bus.Repeat_Cnt     <= '0;
    end else begin
      bus.Wr_Frame_Start <= 1'b0;
      bus.Rd_Frame_Start <= rd_go;
      bus.Wr_Bank        <= wr_bank_nx;
      bus.Rd_Bank        <= rd_bank_nx;
      bus.Wr_Base_Addr   <= ADDR_W'(wr_bank_nx) * BANK_SIZE;
      bus.Rd_Base_Addr   <= ADDR_W'(rd_bank_nx) * BANK_SIZE;
      fresh              <= fresh_after_rd;

      if (rd_go) begin
        bus.Frame_O_Cnt <= bus.Frame_O_Cnt + CNT_W'(1);
        if (!fresh) bus.Repeat_Cnt <= bus.Repeat_Cnt + CNT_W'(1);
      end

      case (state)
        W_IDLE: begin
          if (bus.Enable && wr_rise) begin
            bus.Wr_Frame_Start <= 1'b1;
            state              <= W_ACTIVE;
          end
        end
        W_ACTIVE: begin
          if (wr_rise) state <= W_FLUSH;
        end
        W_FLUSH: begin
          if (bus.Wr_Done) begin
            latest          <= bus.Wr_Bank;
            fresh           <= 1'b1;
            valid           <= 1'b1;
            bus.Frame_I_Cnt <= bus.Frame_I_Cnt + CNT_W'(1);
            if (fresh_after_rd) bus.Drop_Cnt <= bus.Drop_Cnt + CNT_W'(1);
            if (bus.Enable) begin
              bus.Wr_Frame_Start <= 1'b1;
              state              <= W_ACTIVE;
            end else begin
              state <= W_IDLE;
            end
          end else if (wr_rise) begin
            // Next frame began before the flush finished; that frame is lost.
            bus.Drop_Cnt <= bus.Drop_Cnt + CNT_W'(1);
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - directed and random checks of frame_bank_scheduler against a reference model
module tb_frame_bank_scheduler;
  localparam int BANK_NUM = 3;
  localparam int P_IDLE = 0, P_ACTIVE = 1, P_FLUSH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_bank_scheduler_if bus ();
  frame_bank_scheduler dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  int          m_wr, m_rd, m_latest, m_phase;
  bit          m_fresh, m_valid, m_wprev, m_rprev, e_wfs, e_rfs;
  logic [10:0] m_icnt, m_ocnt, m_drop, m_rep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = BANK_NUM - 1; m_latest = 1; m_phase = P_IDLE;
    m_fresh = 0; m_valid = 0; m_wprev = 1; m_rprev = 1;
    e_wfs = 0; e_rfs = 0;
    m_icnt = '0; m_ocnt = '0; m_drop = '0; m_rep = '0;
  endtask

  task automatic model_cycle(input bit en, input bit ws, input bit wd, input bit rs);
    bit wrise, rrise;
    wrise = ws && !m_wprev;
    rrise = rs && !m_rprev;
    m_wprev = ws;
    m_rprev = rs;
    e_wfs = 0;
    e_rfs = 0;
    if (en && m_valid && rrise) begin
      e_rfs = 1;
      m_ocnt++;
      if (m_fresh) begin
        m_rd = m_latest;
        m_fresh = 0;
      end else begin
        m_rep++;
      end
    end
    case (m_phase)
      P_IDLE: if (en && wrise) begin e_wfs = 1; m_phase = P_ACTIVE; end
      P_ACTIVE: if (wrise) m_phase = P_FLUSH;
      default: begin
        if (wd) begin
          if (m_fresh) m_drop++;
          m_latest = m_wr;
          m_fresh = 1;
          m_valid = 1;
          m_icnt++;
          for (int b = BANK_NUM - 1; b >= 0; b--)
            if (b != m_latest && b != m_rd) m_wr = b;
          if (en) begin e_wfs = 1; m_phase = P_ACTIVE; end
          else m_phase = P_IDLE;
        end else if (wrise) begin
          m_drop++;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check("wr_bank", bus.Wr_Bank, m_wr);
    check("rd_bank", bus.Rd_Bank, m_rd);
    check("wr_base", bus.Wr_Base_Addr, (m_wr * 32'h0080_0000) & 32'h0FFF_FFFF);
    check("rd_base", bus.Rd_Base_Addr, (m_rd * 32'h0080_0000) & 32'h0FFF_FFFF);
    check("wr_frame_start", bus.Wr_Frame_Start, e_wfs);
    check("rd_frame_start", bus.Rd_Frame_Start, e_rfs);
    check("frame_i_cnt", bus.Frame_I_Cnt, m_icnt);
    check("frame_o_cnt", bus.Frame_O_Cnt, m_ocnt);
    check("drop_cnt", bus.Drop_Cnt, m_drop);
    check("repeat_cnt", bus.Repeat_Cnt, m_rep);
    check("latest", dut.latest, m_latest);
    check("fresh", dut.fresh, m_fresh);
    check("inv_wr_ne_rd", bus.Wr_Bank != bus.Rd_Bank, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n)
      assert (bus.Wr_Bank != bus.Rd_Bank && bus.Wr_Bank != dut.latest)
      else $error("FAIL invariant wr=%0d rd=%0d latest=%0d", bus.Wr_Bank, bus.Rd_Bank, dut.latest);
  end

  task automatic step(input bit en, input bit ws, input bit wd, input bit rs);
    @(negedge clk);
    rst_n = 1'b1;
    bus.Enable = en;
    bus.Wr_Sync = ws;
    bus.Wr_Done = wd;
    bus.Rd_Sync = rs;
    model_cycle(en, ws, wd, rs);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit ws, input bit rs);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.Enable = 1'b0;
    bus.Wr_Sync = ws;
    bus.Wr_Done = 1'b0;
    bus.Rd_Sync = rs;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic start_frame();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
  endtask

  task automatic end_frame();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
  endtask

  initial begin
    bit en, ws, wd, rs;
    int exp_seq[3] = '{1, 0, 1};
    bus.Enable = 0; bus.Wr_Sync = 0; bus.Wr_Done = 0; bus.Rd_Sync = 0;
    model_reset();

    do_reset(1, 0);
    check("t1_rst_rd_bank", bus.Rd_Bank, 2);
    check("t1_rst_rd_base", bus.Rd_Base_Addr, 32'h0100_0000);
    repeat (3) begin
      step(1, 1, 0, 0);
      check("t1_no_start_held", bus.Wr_Frame_Start, 0);
    end
    start_frame();
    check("t1_start_pulse", bus.Wr_Frame_Start, 1);
    check("t1_start_bank", bus.Wr_Bank, 0);
    check("t1_start_base", bus.Wr_Base_Addr, 0);

    for (int f = 0; f < 3; f++) begin
      end_frame();
      check("t2_wr_bank_seq", bus.Wr_Bank, exp_seq[f]);
    end
    check("t2_icnt", bus.Frame_I_Cnt, 3);
    check("t2_drop", bus.Drop_Cnt, 2);

    do_reset(0, 0);
    start_frame();
    end_frame();
    step(1, 1, 0, 1);
    check("t3_rd_bank", bus.Rd_Bank, 0);
    check("t3_rd_base", bus.Rd_Base_Addr, 0);
    check("t3_rd_start", bus.Rd_Frame_Start, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    check("t3_rd_bank_rep", bus.Rd_Bank, 0);
    check("t3_repeat", bus.Repeat_Cnt, 1);
    check("t3_ocnt", bus.Frame_O_Cnt, 2);

    do_reset(0, 0);
    start_frame();
    end_frame();
    end_frame();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("t4_pre_wr", bus.Wr_Bank, 0);
    check("t4_pre_rd", bus.Rd_Bank, 2);
    check("t4_pre_latest", dut.latest, 1);
    check("t4_pre_fresh", dut.fresh, 1);
    step(1, 1, 1, 1);
    check("t4_rd_bank", bus.Rd_Bank, 1);
    check("t4_latest", dut.latest, 0);
    check("t4_fresh", dut.fresh, 1);
    check("t4_wr_bank", bus.Wr_Bank, 2);
    check("t4_drop", bus.Drop_Cnt, 1);

    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("t5_drop_rise", bus.Drop_Cnt, 2);
    check("t5_no_start", bus.Wr_Frame_Start, 0);
    step(1, 1, 1, 0);
    check("t5_commit_icnt", bus.Frame_I_Cnt, 4);
    check("t5_commit_start", bus.Wr_Frame_Start, 1);

    do_reset(0, 0);
    start_frame();
    repeat (5) end_frame();
    step(1, 0, 0, 0);
    check("t6_icnt5", bus.Frame_I_Cnt, 5);
    do_reset(0, 0);
    check("t6_rst_wr_bank", bus.Wr_Bank, 0);
    check("t6_rst_rd_bank", bus.Rd_Bank, 2);
    check("t6_rst_icnt", bus.Frame_I_Cnt, 0);
    check("t6_rst_wfs", bus.Wr_Frame_Start, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("t6_no_rd_start", bus.Rd_Frame_Start, 0);

    do_reset(0, 0);
    ws = 0; rs = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset(ws, rs);
      end
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) ws = ~ws;
      if ($urandom_range(0, 6) == 0) rs = ~rs;
      wd = ($urandom_range(0, 3) == 0);
      step(en, ws, wd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
